updown_mod_counter: RTL
=======================

// Module: updown_mod_counter
// PURPOSE
//  Parametrised up/down modulo counter: generalises the fixed 4-bit free-running counter.
//  Adds enable, direction, synchronous load, programmable terminal value, wrap/saturate
//  mode, an enable prescaler and status pulses. Timer/event-count building block for the
//  design; all outputs registered.
// PARAMETERS
//  WIDTH       8   counter width in bits; count range 0..limit
//  PRESCALE_W  4   prescaler width; one count step per (prescale+1) enabled cycles
// PORTS
//  clk         in   1            clock, rising edge
//  reset       in   1            asynchronous, active-high; clock clk
//  en          in   1            count enable; prescaler advances only while high
//  up          in   1            1 = count up, 0 = count down; sampled on tick cycle
//  sat_mode    in   1            0 = wrap at bounds, 1 = saturate at bounds
//  limit       in   WIDTH        terminal value (upper bound, inclusive)
//  prescale    in   PRESCALE_W   prescale divisor minus 1 (0 = step every enabled cycle)
//  load        in   1            synchronous load strobe
//  load_val    in   WIDTH        value loaded on load
//  clr_ovf     in   1            clears ovf sticky flag
//  count       out  WIDTH        current count
//  tc          out  1            one-cycle pulse: step hit/crossed a bound (wrap or saturate)
//  ovf         out  1            sticky: set on any tc event, cleared by clr_ovf
// BEHAVIOUR
//  Reset (async): count=0, prescaler=0, tc=0, ovf=0; release takes effect on next edge.
//  Prescaler: pre_cnt increments each clk with en=1; tick = en && (pre_cnt==prescale);
//   pre_cnt -> 0 on tick or load; holds while en=0.
//  Priority per edge: reset > load > tick step > hold.
//  Load: count <= min(load_val, limit); tc not asserted; pending tick discarded.
//  Tick step, up=1:  count<limit -> count+1; count>=limit -> wrap: 0, sat: limit; tc=1.
//  Tick step, up=0:  count>0     -> count-1; count==0     -> wrap: limit, sat: 0; tc=1.
//  count>limit (limit lowered at runtime): up tick treated as bound (wrap 0 / sat limit);
//   down tick decrements normally. No implicit clamp without a tick.
//  Latency: count and tc update on the edge where tick=1, visible the following cycle;
//   tc is high exactly one cycle per bound event (repeats each tick while saturated).
//  ovf: set on tc event; clr_ovf clears; simultaneous set and clr_ovf -> ovf stays 1.
//  limit=0: up wrap stays 0 with tc every tick; down likewise.
//  All arithmetic in WIDTH bits unsigned; no overflow path beyond bounds handling.
//  Direction/mode/limit changes take effect at the next tick; no pipeline state to flush.
// STRUCTURE
//  Shared package counter_pkg: typedef enum {CNT_WRAP, CNT_SAT} cnt_mode_e; default
//   WIDTH/PRESCALE_W localparams shared with other timer blocks.
//  Sub-module tick_prescaler (pre_cnt, tick out; params PRESCALE_W) instantiated once;
//   next-count/bound logic and flags in top module.
// TESTING
//  1 WIDTH=8, prescale=0, limit=9, up, wrap, en=1 from reset: count 0..9,0; tc high
//    the cycle count returns to 0; ovf=1 thereafter.
//  2 prescale=3, limit=255, up: count steps every 4th enabled cycle; drop en 2 cycles
//    mid-period -> period stretches by exactly 2 cycles.
//  3 sat_mode=1, down, load_val=2: counts 2,1,0,0,0; tc pulses on each tick at 0;
//    clr_ovf concurrent with tc leaves ovf=1; clr_ovf alone clears it.
//  4 limit=20, load with load_val=50 -> count=20; load same cycle as tick -> load wins,
//    no tc, prescaler restarts from 0.
//  5 count=15, limit lowered to 10: up tick -> wrap gives 0 (sat gives 10) with tc;
//    down tick -> 14, no tc.
//  6 assert reset mid-count with pending tick: count, tc, ovf go 0 immediately
//    (asynchronously); counting resumes from 0 after release.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared defaults and mode encoding for the timer/counter blocks.
package counter_pkg;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;
    typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides enabled cycles by (prescale+1) into a one-cycle step tick.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

    // A load restarts the period so the step after a load is a full period away.
    always_comb begin
        tick      = en && (pre_cnt_q == prescale);
        pre_cnt_d = (load || tick) ? '0 : en ? pre_cnt_q + 1'b1 : pre_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pre_cnt_q <= '0;
        else       pre_cnt_q <= pre_cnt_d;
    end
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: prescaled up/down counter bounded by 0..limit with wrap or
// saturate at the bounds, synchronous load, terminal-count pulse and sticky overflow.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  sat_mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  clr_ovf,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  ovf
);
    logic             tick, bound;
    cnt_mode_e        mode;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d, ovf_q, ovf_d;

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .prescale (prescale),
        .tick     (tick)
    );

    // Up uses >= so a count left above a lowered limit is treated as at the bound.
    always_comb begin
        mode     = sat_mode ? CNT_SAT : CNT_WRAP;
        bound    = up ? (count_q >= limit) : (count_q == '0);
        step_val = !bound ? (up ? count_q + 1'b1 : count_q - 1'b1)
                 : (mode == CNT_SAT) ? (up ? limit : '0)
                 : (up ? '0 : limit);
        count_d  = load ? ((load_val > limit) ? limit : load_val) : tick ? step_val : count_q;
        tc_d     = !load && tick && bound;
        ovf_d    = tc_d || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
endmodule
